// File: rtl/pio_poll_master.sv
// Avalon-MM read master that polls one PIO word, filters repeated samples and
// queues the results into a show-ahead FIFO presented as a valid/ready stream.
module pio_poll_master #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 2,
    parameter int TARGET_ADDR   = 0,
    parameter int READ_LATENCY  = 1,
    parameter int POLL_INTERVAL = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int CHANGE_ONLY   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic [ADDR_W-1:0]             avm_address,
    output logic                          avm_read,
    input  logic                          avm_waitrequest,
    input  logic [31:0]                   avm_readdata,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int TIMER_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int LAT_W   = 2;

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(POLL_INTERVAL - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD   = LAT_W'(READ_LATENCY - 1);
    localparam logic [LVL_W-1:0]   LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               have_last_q, have_last_d;
    logic [DATA_W-1:0]  last_value_q, last_value_d;
    logic               overflow_q, overflow_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    logic               sample_en;
    logic [DATA_W-1:0]  sample;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic               unused_readdata;

    assign unused_readdata = ^avm_readdata[31:DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (timer_q == '0 && enable) state_d = S_REQ;
            S_REQ:  if (!avm_waitrequest)        state_d = S_WAIT;
            S_WAIT: if (lat_cnt_q == '0)         state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read    = (state_q == S_REQ);
        avm_address = ADDR_W'(TARGET_ADDR);
        sample_en   = (state_q == S_WAIT) && (lat_cnt_q == '0);
    end

    // The interval timer only starts counting once the sample has been taken.
    always_comb begin
        timer_d   = timer_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            S_IDLE: if (timer_q != '0) timer_d = timer_q - 1'b1;
            S_REQ:  if (!avm_waitrequest) lat_cnt_d = LAT_LOAD;
            S_WAIT: begin
                if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - 1'b1;
                else                 timer_d   = TIMER_LOAD;
            end
            default: ;
        endcase
    end

    // A pop in the same cycle frees a slot, so a push at full still succeeds.
    always_comb begin
        sample    = avm_readdata[DATA_W-1:0];
        full      = (level_q == LVL_FULL);
        pop       = (level_q != '0) && out_ready;
        push_req  = sample_en &&
                    ((CHANGE_ONLY == 0) || !have_last_q || (sample != last_value_q));
        push      = push_req && (!full || pop);

        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        have_last_d  = have_last_q;
        last_value_d = last_value_q;
        overflow_d   = overflow_q | (push_req && !push);

        if (push) begin
            mem_d[wr_ptr_q] = sample;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            last_value_d    = sample;
            have_last_d     = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q      <= '0;
            lat_cnt_q    <= '0;
            have_last_q  <= 1'b0;
            last_value_q <= '0;
            overflow_q   <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            timer_q      <= timer_d;
            lat_cnt_q    <= lat_cnt_d;
            have_last_q  <= have_last_d;
            last_value_q <= last_value_d;
            overflow_q   <= overflow_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    always_comb begin
        out_valid  = (level_q != '0);
        out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
        overflow   = overflow_q;
        fifo_level = level_q;
    end

endmodule

// File: doc/pio_poll_master.md
Name: pio_poll_master

Overview:
- Avalon-MM master that periodically reads an 8-bit input PIO slave (e.g. the Sobel result port) at a fixed word address.
- Captures the data, discards unchanged samples, and queues changed samples into a small FIFO.
- Presents queued samples as a valid/ready stream, so fabric logic can consume the result without Nios software polling.

Parameters:
- DATA_W, 8: captured data width, taken from readdata[DATA_W-1:0].
- ADDR_W, 2: master address width (word address).
- TARGET_ADDR, 0: address driven on every read.
- READ_LATENCY, 1: fixed slave read latency in cycles (1..3).
- POLL_INTERVAL, 16: cycles between capture and the next read request (>=1).
- FIFO_DEPTH, 4: output queue depth (power of 2, >=2).
- CHANGE_ONLY, 1: 1 = enqueue only changed values; 0 = enqueue every sample.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous reset, active high.
- enable, in, 1: polling enable.
- avm_address, out, ADDR_W: read address, constant TARGET_ADDR.
- avm_read, out, 1: read request.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: slave read data.
- out_data, out, DATA_W: head-of-queue sample.
- out_valid, out, 1: queue non-empty.
- out_ready, in, 1: consumer accepts the head this cycle.
- overflow, out, 1: sticky flag, a sample was dropped because the queue was full.
- fifo_level, out, log2(FIFO_DEPTH)+1: current occupancy.

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous and active-high on reset; it takes effect at the clk edge where reset=1.
- Reset values:
  - avm_read=0, out_valid=0, out_data=0, overflow=0, fifo_level=0.
  - FSM=IDLE, interval timer=0, have_last=0, last_value=0.
- FSM states:
  - IDLE: timer decrements while nonzero. When timer==0 and enable=1, go to REQ.
  - REQ: avm_read=1. Stay while avm_waitrequest=1. The read is accepted on the cycle where avm_read=1 and avm_waitrequest=0; go to WAIT with lat_cnt=READ_LATENCY-1.
  - WAIT: avm_read=0. Data is valid exactly READ_LATENCY cycles after the accept cycle. The cycle lat_cnt==0 is the sample cycle: capture avm_readdata[DATA_W-1:0], go to IDLE, load timer=POLL_INTERVAL-1.
- Timing:
  - avm_address is always TARGET_ADDR.
  - Minimum poll period with no waitrequest is POLL_INTERVAL+READ_LATENCY+1 cycles.
  - The first read is issued the cycle after reset deasserts, provided enable=1.
- enable deasserted:
  - In REQ or WAIT: the transaction completes normally and the sample is processed. A read is never withdrawn while waitrequest=1.
  - The FSM then holds in IDLE (timer still runs down) until enable=1.
- Enqueue rule:
  - Push when (CHANGE_ONLY==0) or (have_last==0) or (sample != last_value).
  - On a successful push: last_value<=sample, have_last<=1.
  - Push attempted while full and out_ready=0: sample dropped, overflow<=1, last_value unchanged, so the same value is re-detected as a change on a later poll.
- FIFO:
  - Show-ahead: out_data is the head whenever out_valid=1, and is stable while out_valid=1 and out_ready=0.
  - Pop when out_valid and out_ready.
  - Push and pop in the same cycle are both performed, level unchanged. This includes the full case: a pop frees space for the push, and no overflow is flagged.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_data is unspecified when out_valid=0.
- Ignored inputs: upper readdata bits [31:DATA_W] are ignored.
- overflow is cleared only by reset.
- Reset mid-transaction returns everything to reset values immediately. A pending slave response after reset is ignored: the FSM is in IDLE and does not sample.

Test Plan:
1. Basic poll: enable=1, slave returns 0x3C with latency 1, no waitrequest, out_ready=1. Required: read asserted the cycle after reset release; out_valid rises with out_data=0x3C; next read POLL_INTERVAL+2 cycles after the first.
2. Change filter: slave value sequence 0x10,0x10,0x10,0x22,0x22 over five polls, CHANGE_ONLY=1, out_ready=1. Required: exactly two outputs, 0x10 then 0x22. With CHANGE_ONLY=0: five outputs.
3. Waitrequest stall: waitrequest=1 for 5 cycles on the first read. Required: avm_read held high 6 cycles, address stable at 0, single sample captured 1 cycle after the accept cycle.
4. Overflow: out_ready=0, slave increments its value every poll 0x01..0x06, FIFO_DEPTH=4. Required: fifo_level reaches 4; overflow=1 after the 5th poll; drain yields 0x01..0x04. Then with out_ready=1, the next poll enqueues the current value because last_value=0x04.
5. Simultaneous push/pop at full: level=4 and out_ready=1 on a sample cycle with a changed value. Required: level stays 4, overflow stays 0, head advances.
6. Enable/reset mid-op:
   - enable drops during a stalled REQ: read completes, sample enqueued, no further read until enable=1.
   - reset asserted during WAIT: next cycle all outputs at reset values; the stale readdata is not enqueued.
